// File: rtl/multi_pos_manager_if.sv
// ---------------------------------------------------------------------------
// multi_pos_manager_if
//   Bundles the sensor/clear stimulus and the position/speed results of the
//   multi-channel wheel-encoder position manager.
//
//   Parameters : N_CH  - number of sensor channels
//                POS_W - width of every position counter / difference
//                CLK_W - width of the free-running cycle counter
//   Signals    : sensor    [N_CH]        raw encoder inputs, bit i = channel i
//                clear     [2]           bit0 trip+count_clk, bit1 relative+ovf
//                trip_pos  [N_CH*POS_W]  trip counters, channel i at [i*POS_W +: POS_W]
//                rel_pos   [N_CH*POS_W]  rebased relative counters, same packing
//                pos_diff  [N_CH*POS_W]  rel_pos[i] - rel_pos[0]
//                count_clk [CLK_W]       free-running cycle counter
//                rebase                  high for the cycle a rebase was applied
//                rel_ovf   [N_CH]        sticky relative saturation flags
//   Modports   : master drives sensor/clear, slave (the manager) drives results.
// ---------------------------------------------------------------------------
interface multi_pos_manager_if #(
  parameter int N_CH  = 2,
  parameter int POS_W = 16,
  parameter int CLK_W = 32
);
  logic [N_CH-1:0]       sensor;
  logic [1:0]            clear;
  logic [N_CH*POS_W-1:0] trip_pos;
  logic [N_CH*POS_W-1:0] rel_pos;
  logic [N_CH*POS_W-1:0] pos_diff;
  logic [CLK_W-1:0]      count_clk;
  logic                  rebase;
  logic [N_CH-1:0]       rel_ovf;

  modport master (
    output sensor, clear,
    input  trip_pos, rel_pos, pos_diff, count_clk, rebase, rel_ovf
  );

  modport slave (
    input  sensor, clear,
    output trip_pos, rel_pos, pos_diff, count_clk, rebase, rel_ovf
  );
endinterface

// File: rtl/multi_pos_manager.sv
// ---------------------------------------------------------------------------
// multi_pos_manager
//   N-channel wheel-encoder position manager. Each raw sensor is
//   synchronised, optionally debounced and rising-edge detected. Every
//   rising edge bumps a saturating trip counter and a relative counter.
//   The relative counters are rebased jointly (all minus their common
//   minimum) once any of them reaches its MSB, so inter-channel differences
//   survive indefinitely. A free-running cycle counter supports speed
//   measurement.
//
//   Ports : clk   - system clock, rising edge
//           reset - synchronous, active-high, clears every register
//           bus   - multi_pos_manager_if.slave (sensor, clear in; trip_pos,
//                   rel_pos, pos_diff, count_clk, rebase, rel_ovf out)
//
//   Build option: define POS_MGR_DEBOUNCE_EN to insert a per-channel
//   debounce filter of DEB_CYCLES stable cycles after the synchroniser.
// ---------------------------------------------------------------------------
module multi_pos_manager #(
  parameter int N_CH       = 2,
  parameter int POS_W      = 16,
  parameter int CLK_W      = 32,
  parameter int DEB_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  multi_pos_manager_if.slave bus
);

  localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_MAX  = {POS_W{1'b1}};

  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync2_r;
  logic [N_CH-1:0]  filt_s;
  logic [N_CH-1:0]  prev_r;
  logic [N_CH-1:0]  inc_s;

  logic [POS_W-1:0] trip_r    [N_CH];
  logic [POS_W-1:0] rel_r     [N_CH];
  logic [POS_W-1:0] rel_nxt_s [N_CH];
  logic [N_CH-1:0]  ovf_r;
  logic [N_CH-1:0]  ovf_nxt_s;
  logic [CLK_W-1:0] clk_cnt_r;
  logic             rebase_r;

  logic [POS_W-1:0] min_s;
  logic             any_msb_s;
  logic             rebase_cond_s;

  // Two-flop synchroniser for the asynchronous encoder inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {N_CH{1'b0}};
      sync2_r <= {N_CH{1'b0}};
    end else begin
      sync1_r <= bus.sensor;
      sync2_r <= sync1_r;
    end
  end

`ifdef POS_MGR_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt_r [N_CH];
  logic [N_CH-1:0]  deb_lvl_r;

  // Debounce: adopt the synchronised level only after DEB_CYCLES
  // consecutive cycles of disagreement; any reversion restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_lvl_r <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_r[i] <= {DEB_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync2_r[i] != deb_lvl_r[i]) begin
          if (deb_cnt_r[i] == DEB_W'(DEB_CYCLES - 1)) begin
            deb_lvl_r[i] <= sync2_r[i];
            deb_cnt_r[i] <= {DEB_W{1'b0}};
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end
      end
    end
  end

  assign filt_s = deb_lvl_r;
`else
  // DEB_CYCLES has no effect in this build; the filtered level is the
  // second synchroniser stage whatever its value.
  if (DEB_CYCLES >= 1) begin : g_nodeb
    assign filt_s = sync2_r;
  end else begin : g_nodeb_any
    assign filt_s = sync2_r;
  end
`endif

  // Previous filtered level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= {N_CH{1'b0}};
    end else begin
      prev_r <= filt_s;
    end
  end

  assign inc_s = filt_s & ~prev_r;

  // Common minimum and MSB scan across all relative counters
  always_comb begin
    min_s     = rel_r[0];
    any_msb_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (rel_r[i] < min_s) begin
        min_s = rel_r[i];
      end else begin
        min_s = min_s;
      end
      any_msb_s = any_msb_s | rel_r[i][POS_W-1];
    end
    rebase_cond_s = any_msb_s & (min_s != POS_ZERO);
  end

  // Relative next state: rebase subtracts the minimum from every channel
  // and still adds a coincident increment, so nothing is lost. Since the
  // minimum is at least 1 during a rebase, rel - min + 1 cannot overflow.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      rel_nxt_s[i] = rel_r[i];
      ovf_nxt_s[i] = ovf_r[i];
      if (rebase_cond_s) begin
        rel_nxt_s[i] = rel_r[i] - min_s + POS_W'(inc_s[i]);
      end else if (inc_s[i]) begin
        if (rel_r[i] == POS_MAX) begin
          ovf_nxt_s[i] = 1'b1;
        end else begin
          rel_nxt_s[i] = rel_r[i] + POS_ONE;
        end
      end else begin
        rel_nxt_s[i] = rel_r[i];
      end
    end
  end

  // Trip counters: saturating, cleared by clear[0]
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        trip_r[i] <= POS_ZERO;
      end else if (bus.clear[0]) begin
        trip_r[i] <= POS_ZERO;
      end else if (inc_s[i] && (trip_r[i] != POS_MAX)) begin
        trip_r[i] <= trip_r[i] + POS_ONE;
      end else begin
        trip_r[i] <= trip_r[i];
      end
    end
  end

  // Relative counters, overflow flags and rebase strobe; clear[1] wins
  // over rebase and increments
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r    <= {N_CH{1'b0}};
      rebase_r <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        rel_r[i] <= POS_ZERO;
      end
    end else if (bus.clear[1]) begin
      ovf_r    <= {N_CH{1'b0}};
      rebase_r <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        rel_r[i] <= POS_ZERO;
      end
    end else begin
      ovf_r    <= ovf_nxt_s;
      rebase_r <= rebase_cond_s;
      for (int i = 0; i < N_CH; i++) begin
        rel_r[i] <= rel_nxt_s[i];
      end
    end
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_r <= {CLK_W{1'b0}};
    end else if (bus.clear[0]) begin
      clk_cnt_r <= {CLK_W{1'b0}};
    end else begin
      clk_cnt_r <= clk_cnt_r + CLK_W'(1);
    end
  end

  logic [N_CH*POS_W-1:0] trip_pk_s;
  logic [N_CH*POS_W-1:0] rel_pk_s;
  logic [N_CH*POS_W-1:0] diff_pk_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign trip_pk_s[g*POS_W +: POS_W] = trip_r[g];
    assign rel_pk_s[g*POS_W +: POS_W]  = rel_r[g];
    // Two's-complement difference; a joint rebase leaves it unchanged
    assign diff_pk_s[g*POS_W +: POS_W] = rel_r[g] - rel_r[0];
  end

  assign bus.trip_pos  = trip_pk_s;
  assign bus.rel_pos   = rel_pk_s;
  assign bus.pos_diff  = diff_pk_s;
  assign bus.count_clk = clk_cnt_r;
  assign bus.rebase    = rebase_r;
  assign bus.rel_ovf   = ovf_r;

endmodule

// File: tb/tb_multi_pos_manager.sv
// ---------------------------------------------------------------------------
// tb_multi_pos_manager
//   Directed bench for multi_pos_manager. A 16-bit instance covers latency,
//   clears, the joint rebase and reset; an 8-bit instance covers coincident
//   rebase/increment, saturation and count_clk wrap within a short run.
// ---------------------------------------------------------------------------
module tb_multi_pos_manager;

  localparam int DEB = 4;
`ifdef POS_MGR_DEBOUNCE_EN
  localparam int PW  = DEB;
  localparam int LAT = 2 + DEB;
`else
  localparam int PW  = 1;
  localparam int LAT = 2;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rb;

  multi_pos_manager_if #(.N_CH(2), .POS_W(16), .CLK_W(32)) b16 ();
  multi_pos_manager_if #(.N_CH(2), .POS_W(8),  .CLK_W(8))  b8 ();

  multi_pos_manager #(.N_CH(2), .POS_W(16), .CLK_W(32), .DEB_CYCLES(DEB)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  multi_pos_manager #(.N_CH(2), .POS_W(8), .CLK_W(8), .DEB_CYCLES(DEB)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse16(input logic [1:0] m);
    b16.sensor = m;
    repeat (PW) tick();
    b16.sensor = 2'b00;
    repeat (PW) tick();
  endtask

  task automatic pulse8(input logic [1:0] m);
    b8.sensor = m;
    repeat (PW) tick();
    b8.sensor = 2'b00;
    repeat (PW) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    b16.sensor = 2'b00; b16.clear = 2'b00;
    b8.sensor  = 2'b00; b8.clear  = 2'b00;
    repeat (3) tick();

    // Reset state
    check("rst_trip",   b16.trip_pos,  64'h0);
    check("rst_rel",    b16.rel_pos,   64'h0);
    check("rst_diff",   b16.pos_diff,  64'h0);
    check("rst_clk",    b16.count_clk, 64'h0);
    check("rst_rebase", b16.rebase,    64'h0);
    check("rst_ovf",    b16.rel_ovf,   64'h0);

    reset = 1'b0;
    tick();
    check("clk_first", b16.count_clk, 64'h1);
    tick();
    check("clk_second", b16.count_clk, 64'h2);

    // First increment exactly LAT edges after the first high sample
    b16.sensor = 2'b01;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      if (k == PW - 1) b16.sensor = 2'b00;
      if (k == LAT - 1) check("lat_before", b16.trip_pos, 64'h0);
    end
    check("lat_edge_trip", b16.trip_pos, 64'h0000_0001);
    check("lat_edge_rel",  b16.rel_pos,  64'h0000_0001);
    repeat (PW) tick();
    pulse16(2'b01);
    pulse16(2'b01);
    repeat (LAT + PW) tick();
    check("three_trip", b16.trip_pos, 64'h0000_0003);
    check("three_rel",  b16.rel_pos,  64'h0000_0003);
    check("three_diff", b16.pos_diff, 64'hFFFD_0000);

    // clear[0] only: trip and count_clk zero, relative untouched
    b16.clear = 2'b01;
    tick();
    b16.clear = 2'b00;
    check("clr0_clk",  b16.count_clk, 64'h0);
    check("clr0_trip", b16.trip_pos,  64'h0);
    check("clr0_rel",  b16.rel_pos,   64'h0000_0003);
    tick();
    check("clr0_restart", b16.count_clk, 64'h1);

    // clear both
    b16.clear = 2'b11;
    tick();
    b16.clear = 2'b00;
    check("clr3_rel",  b16.rel_pos,   64'h0);
    check("clr3_diff", b16.pos_diff,  64'h0);
    check("clr3_clk",  b16.count_clk, 64'h0);

    // Both channels together up to 0x8000: exactly one rebase back to 0
    rb = 0;
    for (int p = 0; p < 32768; p++) begin
      b16.sensor = 2'b11;
      repeat (PW) begin tick(); rb += int'(b16.rebase); end
      b16.sensor = 2'b00;
      repeat (PW) begin tick(); rb += int'(b16.rebase); end
    end
    repeat (LAT + 2) begin tick(); rb += int'(b16.rebase); end
    check("rb16_count", rb,           64'd1);
    check("rb16_rel",   b16.rel_pos,  64'h0);
    check("rb16_trip",  b16.trip_pos, 64'h8000_8000);
    check("rb16_diff",  b16.pos_diff, 64'h0);
    check("rb16_ovf",   b16.rel_ovf,  64'h0);

    // 8-bit: ch0 = 5, ch1 = 0x7F, then ch1 reaches 0x80 and the rebase
    // edge coincides with an increment on ch0
    repeat (5) pulse8(2'b01);
    repeat (127) pulse8(2'b10);
    repeat (LAT + PW) tick();
    check("co_pre_rel",  b8.rel_pos,  64'h7F05);
    check("co_pre_diff", b8.pos_diff, 64'h7A00);
    b8.sensor = 2'b10;
    tick();
    for (int k = 1; k <= LAT + 1; k++) begin
      b8.sensor = {(k <= PW - 1), (k <= PW)};
      tick();
      if (k == LAT) begin
        check("co_peak_rel", b8.rel_pos, 64'h8005);
        check("co_peak_rb",  b8.rebase,  64'h0);
      end
      if (k == LAT + 1) begin
        check("co_rb",   b8.rebase,   64'h1);
        check("co_rel",  b8.rel_pos,  64'h7B01);
        check("co_diff", b8.pos_diff, 64'h7A00);
      end
    end
    b8.sensor = 2'b00;
    repeat (2 * PW + LAT) tick();
    check("co_trip", b8.trip_pos, 64'h8006);

    // 8-bit saturation with ch1 idle: min stays 0, no rebase
    b8.clear = 2'b11;
    tick();
    b8.clear = 2'b00;
    check("sat_clr", b8.trip_pos, 64'h0);
    rb = 0;
    for (int p = 0; p < 256; p++) begin
      b8.sensor = 2'b01;
      repeat (PW) begin tick(); rb += int'(b8.rebase); end
      b8.sensor = 2'b00;
      repeat (PW) begin tick(); rb += int'(b8.rebase); end
    end
    repeat (LAT + 2) begin tick(); rb += int'(b8.rebase); end
    check("sat_rb",   rb,          64'd0);
    check("sat_trip", b8.trip_pos, 64'h00FF);
    check("sat_rel",  b8.rel_pos,  64'h00FF);
    check("sat_ovf",  b8.rel_ovf,  64'h1);
    check("sat_diff", b8.pos_diff, 64'h0100);
    b8.clear = 2'b10;
    tick();
    b8.clear = 2'b00;
    check("clr1_rel",  b8.rel_pos,  64'h0);
    check("clr1_ovf",  b8.rel_ovf,  64'h0);
    check("clr1_trip", b8.trip_pos, 64'h00FF);

    // count_clk wraps modulo 2^CLK_W
    b8.clear = 2'b01;
    tick();
    b8.clear = 2'b00;
    check("wrap_zero", b8.count_clk, 64'h0);
    repeat (255) tick();
    check("wrap_max", b8.count_clk, 64'hFF);
    tick();
    check("wrap_roll", b8.count_clk, 64'h0);

    // Reset mid-pulse, then release with the sensor still high: one count
    b16.sensor = 2'b01;
    tick();
    reset = 1'b1;
    tick();
    check("mrst_trip", b16.trip_pos,  64'h0);
    check("mrst_rel",  b16.rel_pos,   64'h0);
    check("mrst_clk",  b16.count_clk, 64'h0);
    check("mrst_ovf8", b8.rel_ovf,    64'h0);
    reset = 1'b0;
    repeat (LAT) tick();
    check("rel_hi_before", b16.trip_pos, 64'h0);
    tick();
    check("rel_hi_count", b16.trip_pos, 64'h0000_0001);
    repeat (4) tick();
    check("rel_hi_once", b16.trip_pos, 64'h0000_0001);
    b16.sensor = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pos_manager.md
# multi_pos_manager

Parametrised N-channel wheel-encoder position manager for the motor speed/position subsystem. It synchronises and edge-detects each sensor and keeps two per-channel counters: a trip counter and a relative counter. The relative counters are rebased jointly so they never overflow while inter-channel differences are preserved. It also provides a free-running clock counter for speed computation and per-channel differences against channel 0.

## Interface
Parameters:
- N_CH, 2, number of sensor channels (>=1)
- POS_W, 16, width of every position counter and difference output
- CLK_W, 32, width of count_clk
- DEB_CYCLES, 4, debounce stability length in cycles (used only when debounce is compiled in; >=1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears every register
- sensor  in  N_CH  raw asynchronous encoder inputs, bit i = channel i
- clear  in  2  bit0 clears trip counters and count_clk; bit1 clears relative counters and overflow flags
- trip_pos  out  N_CH*POS_W  trip counter, channel i at [i*POS_W +: POS_W]
- rel_pos  out  N_CH*POS_W  relative (rebased) counters, same packing
- pos_diff  out  N_CH*POS_W  rel_pos[i] - rel_pos[0], two's complement; channel 0 slice is always 0
- count_clk  out  CLK_W  free-running cycle counter
- rebase  out  1  high for the one cycle in which a rebase is applied
- rel_ovf  out  N_CH  sticky per-channel relative-counter saturation flag

## Operation
- Input path per channel: 2-flop synchroniser -> optional debounce -> level register `prev`. A count event (`inc[i]`) is the rising edge of the filtered level. Falling edges are ignored.
- Trip counter:
  - clear[0] forces it to 0.
  - Otherwise it increments on inc[i] and saturates at 2^POS_W-1; it does not wrap.
- count_clk:
  - clear[0] forces it to 0.
  - Otherwise it increments every cycle and wraps modulo 2^CLK_W.
- Relative counters and rebase:
  - The rebase condition is: any rel_pos MSB set AND min over all channels > 0.
  - When the condition holds, every channel updates to rel - min + inc, with min computed from the current registered values. rebase is high that cycle.
  - Otherwise a channel updates to rel + inc.
  - If a channel at 2^POS_W-1 gets inc without a rebase, it holds at max and sets rel_ovf[i].
  - clear[1] forces all relative counters and rel_ovf to 0. It overrides rebase and inc, and rebase stays low.
- pos_diff is combinational from rel_pos. It is unaffected by rebase unless a channel has saturated.
- Priority per register: reset > clear bit > rebase/inc.
- Reset values: trip_pos, rel_pos, pos_diff, count_clk all 0; rebase 0; rel_ovf 0; synchroniser, debounce and prev state 0.
- Releasing reset with a sensor already high produces one count (a 0->1 edge on the filtered level).

## Timing
- Let E0 be the first clk edge that samples a sensor high.
- Without debounce, trip_pos and rel_pos change at edge E0+2. The first synchroniser stage captures at E0, the second at E0+1, and inc is asserted between E0+1 and E0+2.
- With debounce, the filtered level changes DEB_CYCLES edges later, so counters change at E0+2+DEB_CYCLES.
- A sensor pulse must be high and low for at least 1 cycle each after synchronisation to be counted. Maximum count rate is one per 2 cycles per channel.
- clear acts at the edge where it is sampled; counters read 0 the following cycle.
- A clear held for multiple cycles keeps counters at 0, and count_clk restarts at 0 on the first cycle after release.
- rebase and its counter update occur at the same edge. An inc coincident with a rebase is never lost.
- clear[0] and clear[1] are independent. With both set, every counter goes to 0 at the same edge.

## Configuration
- Macro: POS_MGR_DEBOUNCE_EN.
- Defined: each channel has a counter of ceil(log2(DEB_CYCLES+1)) bits. The filtered level takes the synchronised value only after DEB_CYCLES consecutive cycles of that value differing from the current filtered level. Any reversion resets the counter. Reset clears both the counter and the filtered level.
- Undefined: filtered level = second synchroniser stage, DEB_CYCLES is ignored, and no debounce registers exist.

## Test plan
- Reset, then drive 3 sensor[0] pulses (1 high, 1 low each): trip_pos[0]=rel_pos[0]=3, trip_pos[1]=0, pos_diff[1]=0xFFFD; first increment appears exactly 2 edges after first sample.
- POS_W=16, toggle both channels together for 32768 pulses: rebase pulses once when both reach 0x8000, both rel_pos return to 0x0000, trip_pos=0x8000, pos_diff=0, rel_ovf=0.
- Hold channel 1 idle, pulse channel 0 65536 times: no rebase (min=0), rel_pos[0] saturates at 0xFFFF, rel_ovf[0]=1, trip_pos[0]=0xFFFF; then clear=2'b10 -> rel_pos all 0, rel_ovf=0, trip_pos unchanged.
- Apply clear=2'b01 for 1 cycle mid-count: count_clk and trip_pos read 0 next cycle, rel_pos unchanged; clear=2'b11 zeros all; reset asserted mid-pulse zeros every output next cycle.
- Force rebase condition and an inc on channel 0 at the same edge: rel_pos[0] = old - min + 1, pos_diff[1] decreases by exactly 1.
- With POS_MGR_DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle glitch produces no count; a 4-cycle high produces one count at E0+6.
